a2d_scan_seq: RTL

//  Upstream sequencer for the A2D SPI interface. On a periodic tick it scans channels
//  0..NUM_CHNL-1, pulsing strt_cnv with chnnl for each conversion and collecting res on
//  cnv_cmplt. It averages 2^AVG_SHIFT conversions per channel into a per-channel result

---
 rtl/a2d_scan_seq_if.sv | 25 ++
 rtl/a2d_scan_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/a2d_scan_seq_if.sv
// Signal bundle between the A2D scan sequencer, the A2D SPI front end and the result readers.
// The sequencer takes the master modport; the environment side takes the slave modport.
interface a2d_scan_seq_if;
    logic        en;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [2:0]  rd_chnl;
    logic [11:0] rd_data;
    logic        scan_done;
    logic        tmo_err;
    logic        ovr_err;
    logic        clr_err;

    modport master (
        input  en, cnv_cmplt, res, rd_chnl, clr_err,
        output strt_cnv, chnnl, rd_data, scan_done, tmo_err, ovr_err
    );

    modport slave (
        output en, cnv_cmplt, res, rd_chnl, clr_err,
        input  strt_cnv, chnnl, rd_data, scan_done, tmo_err, ovr_err
    );
endinterface

// File: rtl/a2d_scan_seq.sv
// Periodic A2D channel scanner: requests 2^AVG_SHIFT conversions per channel, averages
// them into a per-channel result bank, and flags conversion timeouts and scan overruns.
module a2d_scan_seq #(
    parameter int NUM_CHNL  = 8,
    parameter int PERIOD    = 50000,
    parameter int AVG_SHIFT = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic           clk,
    input  logic           rst,
    a2d_scan_seq_if.master bus
);
    localparam int CNT_W = $clog2(PERIOD);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int ACC_W = 12 + AVG_SHIFT;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 2);
    localparam logic [3:0]       SAMP_LAST = 4'((1 << AVG_SHIFT) - 1);
    localparam logic [2:0]       CH_LAST   = 3'(NUM_CHNL - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        STORE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ch_q, ch_d;
    logic [3:0]       samp_q, samp_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_hit_q, tmo_hit_d;
    logic             tmo_err_q, tmo_err_d;
    logic             ovr_err_q, ovr_err_d;
    logic [11:0]      result_q [8];

    logic             tick;
    logic             set_tmo;
    logic             set_ovr;
    logic             wr_en;
    logic [11:0]      wr_data;
    logic             scan_done;
    logic [11:0]      avg;

    assign tick    = (cnt_q == CNT_LAST);
    assign set_ovr = tick && (state_q != IDLE);
    assign avg     = 12'(acc_q >> AVG_SHIFT);

    always_comb begin
        cnt_d = '0;
        if (bus.en && !tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: every variable gets its default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        samp_d    = samp_q;
        acc_d     = acc_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit_d = tmo_hit_q;
        set_tmo   = 1'b0;
        wr_en     = 1'b0;
        wr_data   = avg;
        scan_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = START;
                    ch_d    = '0;
                    samp_d  = '0;
                    acc_d   = '0;
                end
            end
            START: begin
                state_d   = WAIT;
                tmo_cnt_d = '0;
                tmo_hit_d = 1'b0;
            end
            WAIT: begin
                if (bus.cnv_cmplt) begin
                    acc_d = acc_q + ACC_W'(bus.res);
                    if (samp_q == SAMP_LAST) begin
                        state_d = STORE;
                    end else begin
                        samp_d  = samp_q + 4'd1;
                        state_d = START;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Abandon when this cycle's increment would reach TIMEOUT-1; the
                    // saturated code goes in now and STORE leaves it alone.
                    set_tmo   = 1'b1;
                    tmo_hit_d = 1'b1;
                    wr_en     = 1'b1;
                    wr_data   = 12'hFFF;
                    state_d   = STORE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            STORE: begin
                wr_en = !tmo_hit_q;
                if (ch_q == CH_LAST) begin
                    scan_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    ch_d    = ch_q + 3'd1;
                    samp_d  = '0;
                    acc_d   = '0;
                    state_d = START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Set wins over a simultaneous clear.
    assign tmo_err_d = set_tmo | (tmo_err_q & ~bus.clr_err);
    assign ovr_err_d = set_ovr | (ovr_err_q & ~bus.clr_err);

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of the order the simulator runs the blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            samp_q    <= '0;
            acc_q     <= '0;
            tmo_cnt_q <= '0;
            tmo_hit_q <= 1'b0;
            tmo_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            samp_q    <= samp_d;
            acc_q     <= acc_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_hit_q <= tmo_hit_d;
            tmo_err_q <= tmo_err_d;
            ovr_err_q <= ovr_err_d;
        end
    end

    // NOTE: the result bank is reset because readers must see 0 after reset; this
    // keeps it in flops rather than a RAM macro, which is fine at eight words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                result_q[i] <= '0;
            end
        end else if (wr_en) begin
            result_q[ch_q] <= wr_data;
        end
    end

    assign bus.strt_cnv  = (state_q == START);
    assign bus.chnnl     = ch_q;
    assign bus.scan_done = scan_done;
    assign bus.tmo_err   = tmo_err_q;
    assign bus.ovr_err   = ovr_err_q;
    assign bus.rd_data   = ({1'b0, bus.rd_chnl} < 4'(NUM_CHNL)) ? result_q[bus.rd_chnl] : 12'h000;
endmodule
